seg7_scan_driver: RTL and testbench

//   Time-multiplexed driver for a DIGITS-wide common-select 7-segment display.

---
 rtl/seg7_scan_driver_if.sv | 26 ++
 rtl/seg7_scan_driver.sv | 125 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display data and pin bundle for seg7_scan_driver.
// master = application side, slave = scan driver.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] din;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   digit_en;
  logic                blank_lz;
  logic                load;
  logic [7:0]          seg_out;
  logic [DIGITS-1:0]   an_out;
  logic                frame_done;

  modport master (
    output din, dp_in, digit_en,
    output blank_lz, load,
    input  seg_out, an_out, frame_done
  );

  modport slave (
    input  din, dp_in, digit_en,
    input  blank_lz, load,
    output seg_out, an_out, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with
// frame-synchronous double-buffered display data.
module seg7_scan_driver #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int DEAD     = 4,
  parameter bit HEX_MODE = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  seg7_scan_driver_if.slave  bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] disp_d;
  logic [4*DIGITS-1:0] pend_d;
  logic [DIGITS-1:0]   disp_dp;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_v;

  logic                last_slot;
  logic                wrap;
  logic [3:0]          nib;
  logic [6:0]          segs;
  logic [DIGITS-1:0]   zero_run;
  logic                run;
  logic                blanked;
  logic                lit;
  logic [7:0]          seg_nx;
  logic [DIGITS-1:0]   an_nx;

  assign last_slot = (cnt == CW'(SCAN_DIV - 1));
  assign wrap = last_slot && (idx == IW'(DIGITS - 1));
  assign nib = disp_d[{idx, 2'b00} +: 4];

  always_comb begin
    segs = 7'b0000000;
    case (nib)
      4'h0: segs = 7'b1111110;
      4'h1: segs = 7'b0110000;
      4'h2: segs = 7'b1101101;
      4'h3: segs = 7'b1111001;
      4'h4: segs = 7'b0110011;
      4'h5: segs = 7'b1011011;
      4'h6: segs = 7'b1011111;
      4'h7: segs = 7'b1110000;
      4'h8: segs = 7'b1111111;
      4'h9: segs = 7'b1111011;
      4'hA: segs = HEX_MODE ? 7'b1110111 : '0;
      4'hB: segs = HEX_MODE ? 7'b0011111 : '0;
      4'hC: segs = HEX_MODE ? 7'b1001110 : '0;
      4'hD: segs = HEX_MODE ? 7'b0111101 : '0;
      4'hE: segs = HEX_MODE ? 7'b1001111 : '0;
      4'hF: segs = HEX_MODE ? 7'b1000111 : '0;
      default: segs = 7'b0000000;
    endcase
  end

  // zero_run[i]: digits i..DIGITS-1 of the committed data are all zero
  always_comb begin
    zero_run = '0;
    run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run = run && (disp_d[4*i +: 4] == 4'd0);
      zero_run[i] = run;
    end
  end

  assign blanked = bus.blank_lz && zero_run[idx]
                   && (idx != '0);
  assign lit = (cnt >= CW'(DEAD)) && bus.digit_en[idx];

  always_comb begin
    seg_nx = '0;
    an_nx  = '0;
    if (lit) begin
      an_nx = DIGITS'(1) << idx;
      if (!blanked) seg_nx = {segs, disp_dp[idx]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      idx            <= '0;
      disp_d         <= '0;
      disp_dp        <= '0;
      pend_d         <= '0;
      pend_dp        <= '0;
      pend_v         <= 1'b0;
      bus.seg_out    <= '0;
      bus.an_out     <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.seg_out    <= seg_nx;
      bus.an_out     <= an_nx;
      bus.frame_done <= wrap;
      if (last_slot) begin
        cnt <= '0;
        idx <= wrap ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (bus.load) begin
        pend_d  <= bus.din;
        pend_dp <= bus.dp_in;
        pend_v  <= 1'b1;
      end
      // a load on the wrap cycle wins over anything pending
      if (wrap) begin
        pend_v <= 1'b0;
        if (bus.load) begin
          disp_d  <= bus.din;
          disp_dp <= bus.dp_in;
        end else if (pend_v) begin
          disp_d  <= pend_d;
          disp_dp <= pend_dp;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver
// (DIGITS=8, SCAN_DIV=16, DEAD=4).
module tb_seg7_scan_driver;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_pass;

  seg7_scan_driver_if #(.DIGITS(8)) b0 ();
  seg7_scan_driver_if #(.DIGITS(8)) b1 ();

  assign b1.din      = b0.din;
  assign b1.dp_in    = b0.dp_in;
  assign b1.digit_en = b0.digit_en;
  assign b1.blank_lz = b0.blank_lz;
  assign b1.load     = b0.load;

  seg7_scan_driver #(
    .DIGITS(8), .SCAN_DIV(16),
    .DEAD(4), .HEX_MODE(1'b1)
  ) dut_hex (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );

  seg7_scan_driver #(
    .DIGITS(8), .SCAN_DIV(16),
    .DEAD(4), .HEX_MODE(1'b0)
  ) dut_dec (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // posedges since reset release; state index = cyc, outputs show cyc-1
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic wait_slot(input int d, input int c);
    int  t;
    bit  ok;
    t  = d * 16 + c;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cyc >= 1 && ((cyc - 1) % 128) == t) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("slot_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] d,
                         input logic [7:0] dp);
    b0.din   = d;
    b0.dp_in = dp;
    b0.load  = 1'b1;
    @(negedge clk);
    b0.load  = 1'b0;
  endtask

  // called on the negedge where rst_n has just been released
  task automatic check_restart(input string tag);
    bit bad;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (b0.an_out !== 8'h00) bad = 1'b1;
      if (b0.seg_out !== 8'h00) bad = 1'b1;
    end
    chk({tag, "_dead"}, {31'd0, bad}, 32'd0);
    @(negedge clk);
    chk({tag, "_an0"}, {24'd0, b0.an_out}, 32'h01);
    chk({tag, "_seg0"}, {24'd0, b0.seg_out}, 32'hFC);
  endtask

  initial begin
    int bad_an;
    int bad_fd;
    int n_fd;
    bit exp_fd;
    n_chk       = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    b0.din      = '0;
    b0.dp_in    = '0;
    b0.digit_en = 8'hFF;
    b0.blank_lz = 1'b0;
    b0.load     = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_seg", {24'd0, b0.seg_out}, 32'h0);
    chk("rst_an", {24'd0, b0.an_out}, 32'h0);
    chk("rst_fd", {31'd0, b0.frame_done}, 32'h0);
    rst_n = 1'b1;
    check_restart("rel");

    do_load(32'h0000_3A07, 8'h02);
    wait_slot(2, 8);
    chk("pre_commit", {24'd0, b0.seg_out}, 32'hFC);
    wait_slot(7, 14);
    chk("fd_low", {31'd0, b0.frame_done}, 32'h0);
    wait_slot(7, 15);
    chk("fd_high", {31'd0, b0.frame_done}, 32'h1);
    wait_slot(0, 8);
    chk("d0_seg", {24'd0, b0.seg_out}, 32'hE0);
    chk("d0_an", {24'd0, b0.an_out}, 32'h01);
    wait_slot(1, 8);
    chk("d1_dp", {24'd0, b0.seg_out}, 32'hFD);
    wait_slot(2, 8);
    chk("d2_hexA", {24'd0, b0.seg_out}, 32'hEE);
    chk("d2_decA", {24'd0, b1.seg_out}, 32'h00);
    wait_slot(3, 8);
    chk("d3_seg", {24'd0, b0.seg_out}, 32'hF2);
    wait_slot(5, 8);
    chk("d5_seg", {24'd0, b0.seg_out}, 32'hFC);
    chk("d5_an", {24'd0, b0.an_out}, 32'h20);

    b0.blank_lz = 1'b1;
    wait_slot(6, 8);
    chk("lz6_an", {24'd0, b0.an_out}, 32'h40);
    chk("lz6_seg", {24'd0, b0.seg_out}, 32'h00);
    wait_slot(0, 8);
    chk("lz0_seg", {24'd0, b0.seg_out}, 32'hE0);
    wait_slot(3, 8);
    chk("lz3_seg", {24'd0, b0.seg_out}, 32'hF2);
    wait_slot(4, 8);
    chk("lz4_an", {24'd0, b0.an_out}, 32'h10);
    chk("lz4_seg", {24'd0, b0.seg_out}, 32'h00);
    do_load(32'h0, 8'h00);
    wait_slot(0, 8);
    chk("lzz0_seg", {24'd0, b0.seg_out}, 32'hFC);
    wait_slot(1, 8);
    chk("lzz1_seg", {24'd0, b0.seg_out}, 32'h00);
    chk("lzz1_an", {24'd0, b0.an_out}, 32'h02);

    b0.blank_lz = 1'b0;
    do_load(32'h0000_000B, 8'h00);
    wait_slot(0, 8);
    chk("hexB", {24'd0, b0.seg_out}, 32'h3E);
    chk("decB_seg", {24'd0, b1.seg_out}, 32'h00);
    chk("decB_an", {24'd0, b1.an_out}, 32'h01);

    b0.digit_en = 8'hFE;
    bad_an = 0;
    bad_fd = 0;
    n_fd   = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      exp_fd = ((cyc - 1) % 128) == 127;
      if (b0.an_out[0] !== 1'b0) bad_an++;
      if (b0.frame_done !== exp_fd) bad_fd++;
      if (b0.frame_done === 1'b1) n_fd++;
    end
    chk("en_an0", bad_an, 32'd0);
    chk("fd_period", bad_fd, 32'd0);
    chk("fd_count", n_fd, 32'd2);
    wait_slot(1, 3);
    chk("en_dead13", {24'd0, b0.an_out}, 32'h00);
    wait_slot(1, 4);
    chk("en_on14", {24'd0, b0.an_out}, 32'h02);
    b0.digit_en = 8'hFF;

    do_load(32'h0000_0001, 8'h00);
    wait_slot(7, 14);
    do_load(32'h0000_0005, 8'h00);
    wait_slot(0, 8);
    chk("wrap_load", {24'd0, b0.seg_out}, 32'hB6);
    wait_slot(0, 8);
    chk("pend_drop", {24'd0, b0.seg_out}, 32'hB6);

    wait_slot(2, 10);
    chk("pre_rst_an", {24'd0, b0.an_out}, 32'h04);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an", {24'd0, b0.an_out}, 32'h0);
    chk("mid_rst_seg", {24'd0, b0.seg_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_restart("mid");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
